btn_cmd_encoder: RTL and testbench

BTN_CMD_ENCODER -- requirements
Module: btn_cmd_encoder

---
 rtl/btn_cmd_encoder.sv | 175 +++++++++++++++++
 tb/tb_btn_cmd_encoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cmd_encoder.sv
// Button-to-UART command encoder: five buttons are synchronised, debounced and
// edge-detected; each press queues one command byte that a small FSM hands to a UART.
module btn_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int FIFO_DEPTH      = 4,
  parameter int BUSY_TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnC,
  input  logic       uart_tx_busy,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_en,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int TCW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(BUSY_TIMEOUT - 1);
  localparam logic [PW-1:0]  DEPTH_PTR = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [4:0]          btn_s, sync1_r, sync2_r, deb_r, deb_prev_r, armed_r, press_s;
  logic [1:0]          prime_r;
  logic [4:0][DCW-1:0] db_cnt_r;
  logic [7:0]          push_data_s;
  logic                push_s, wr_en_s, empty_s, pop_s, load_s;
  logic [PW-1:0]       wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [7:0]          mem_r [FIFO_DEPTH];
  logic                fifo_full_r, overflow_r, tx_en_r;
  logic [7:0]          tx_data_r;
  state_t              state_r, state_nxt_s;
  logic [TCW-1:0]      tmo_r;

  assign btn_s = {btnU, btnD, btnL, btnR, btnC};

  // Synchronise, debounce and edge-detect all buttons. A button only becomes
  // armed once it has been seen released after reset, so a held button is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r    <= 5'b00000;
      sync2_r    <= 5'b00000;
      deb_r      <= 5'b00000;
      deb_prev_r <= 5'b00000;
      armed_r    <= 5'b00000;
      prime_r    <= 2'b00;
      db_cnt_r   <= {(5 * DCW){1'b0}};
    end else begin
      sync1_r    <= btn_s;
      sync2_r    <= sync1_r;
      deb_prev_r <= deb_r;
      prime_r    <= {prime_r[0], 1'b1};
      for (int i = 0; i < 5; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          db_cnt_r[i] <= {DCW{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_cnt_r[i] <= {DCW{1'b0}};
          deb_r[i]    <= sync2_r[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DCW'(1);
        end
        if (prime_r[1] && !sync2_r[i] && !deb_r[i]) begin
          armed_r[i] <= 1'b1;
        end
      end
    end
  end

  assign press_s = deb_r & ~deb_prev_r & armed_r;
  assign push_s  = |press_s;

  // Keep only the highest-priority press of the cycle (U > D > L > R > C).
  always_comb begin
    push_data_s = 8'h00;
    if (press_s[4])      push_data_s = 8'h55;
    else if (press_s[3]) push_data_s = 8'h44;
    else if (press_s[2]) push_data_s = 8'h4C;
    else if (press_s[1]) push_data_s = 8'h32;
    else if (press_s[0]) push_data_s = 8'h58;
    else                 push_data_s = 8'h00;
  end

  assign empty_s      = (wr_ptr_r == rd_ptr_r);
  assign wr_en_s      = push_s && (!fifo_full_r || pop_s);
  assign wr_ptr_nxt_s = wr_en_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
  assign rd_ptr_nxt_s = pop_s ? rd_ptr_r + PW'(1) : rd_ptr_r;

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
  end

  // Queue pointers, registered full flag and sticky drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      fifo_full_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      fifo_full_r <= ((wr_ptr_nxt_s - rd_ptr_nxt_s) == DEPTH_PTR);
      overflow_r  <= overflow_r | (push_s && fifo_full_r && !pop_s);
    end
  end

  // Send FSM state register and the wait-for-busy timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      tmo_r   <= {TCW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      tmo_r   <= (state_r == WAIT_BUSY) ? tmo_r + TCW'(1) : {TCW{1'b0}};
    end
  end

  // Send FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:      if (!empty_s && !uart_tx_busy) state_nxt_s = SEND; else state_nxt_s = IDLE;
      SEND:      state_nxt_s = WAIT_BUSY;
      WAIT_BUSY: if (uart_tx_busy)              state_nxt_s = WAIT_DONE;
                 else if (tmo_r == TMO_LAST)    state_nxt_s = IDLE;
                 else                           state_nxt_s = WAIT_BUSY;
      WAIT_DONE: if (!uart_tx_busy)             state_nxt_s = IDLE; else state_nxt_s = WAIT_DONE;
      default:   state_nxt_s = IDLE;
    endcase
  end

  // Send FSM outputs: pop while in SEND, load the transmit register on entry to it.
  always_comb begin
    pop_s  = 1'b0;
    load_s = 1'b0;
    case (state_r)
      SEND:    pop_s = 1'b1;
      default: pop_s = 1'b0;
    endcase
    if (state_nxt_s == SEND) load_s = 1'b1;
    else                     load_s = 1'b0;
  end

  // Registered strobe and data towards the transmitter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_en_r   <= 1'b0;
      tx_data_r <= 8'h00;
    end else begin
      tx_en_r <= load_s;
      if (load_s) tx_data_r <= mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  assign uart_tx_en   = tx_en_r;
  assign uart_tx_data = tx_data_r;
  assign fifo_full    = fifo_full_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_btn_cmd_encoder.sv
// Bench for btn_cmd_encoder: directed scenarios followed by randomized presses
// compared against a queue-based model of the command stream.
module tb_btn_cmd_encoder;

  localparam int DEB = 4;
  localparam int DEPTH = 4;
  localparam int TMO = 16;
  // Press-to-strobe delay: two sync flops, DEB stable cycles, then two cycles to SEND.
  localparam int LAT = 2 + DEB + 2;
  localparam logic [7:0] CODE_TBL [5] = '{8'h58, 8'h32, 8'h4C, 8'h44, 8'h55};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn_v = 5'b0;
  logic       busy_man = 1'b0, busy_auto = 1'b0, auto_mode = 1'b0;
  logic       uart_tx_busy;
  logic [7:0] uart_tx_data;
  logic       uart_tx_en, fifo_full, overflow;

  int checks = 0, failures = 0, cyc = 0, double_en = 0;
  logic [7:0] sent_q [$];
  int         sent_cyc [$];
  logic [7:0] exp_q [$];
  int base, c0, hold;
  logic [4:0] m;
  logic en_prev = 1'b0;

  assign uart_tx_busy = auto_mode ? busy_auto : busy_man;

  btn_cmd_encoder #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .btnU(btn_v[4]), .btnD(btn_v[3]), .btnL(btn_v[2]), .btnR(btn_v[1]), .btnC(btn_v[0]),
    .uart_tx_busy(uart_tx_busy), .uart_tx_data(uart_tx_data), .uart_tx_en(uart_tx_en),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with its byte and cycle; count back-to-back strobes.
  initial forever begin
    @(negedge clk);
    if (uart_tx_en) begin
      sent_q.push_back(uart_tx_data);
      sent_cyc.push_back(cyc);
    end
    if (uart_tx_en && en_prev) double_en++;
    en_prev = uart_tx_en;
  end

  // UART model: busy rises the cycle after a strobe and stays up 1..6 cycles.
  initial forever begin
    @(negedge clk);
    if (uart_tx_en) begin
      @(posedge clk); #1 busy_auto = 1'b1;
      repeat ($urandom_range(6, 1)) @(posedge clk);
      #1 busy_auto = 1'b0;
    end
  end

  function automatic logic [7:0] code_of(input logic [4:0] mask);
    for (int i = 4; i >= 0; i--) if (mask[i]) return CODE_TBL[i];
    return 8'h00;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [4:0] mask, input int h, input int gap);
    btn_v = mask;
    tick(h);
    btn_v = 5'b0;
    tick(gap);
  endtask

  task automatic wait_sent(input int n, input int budget, input string tag);
    int k = 0;
    while (sent_q.size() < n && k < budget) begin tick(1); k++; end
    check(tag, sent_q.size(), n);
  endtask

  function automatic logic [31:0] sent_at(input int i);
    return (i < sent_q.size()) ? {24'h0, sent_q[i]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    // Reset state
    tick(3);
    check("rst_en", uart_tx_en, 1'b0);
    check("rst_data", uart_tx_data, 8'h00);
    check("rst_full", fifo_full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    tick(5);

    // Single U press, busy one cycle after the strobe for 50 cycles
    c0 = cyc;
    btn_v = 5'b10000;
    wait_sent(1, 40, "u_count");
    busy_man = 1'b1;
    tick(11);
    btn_v = 5'b0;
    tick(39);
    busy_man = 1'b0;
    tick(30);
    check("u_count_after", sent_q.size(), 1);
    check("u_byte", sent_at(0), 8'h55);
    check("u_latency", (sent_cyc.size() > 0) ? sent_cyc[0] : -1, c0 + LAT);
    check("u_data_hold", uart_tx_data, 8'h55);

    // L glitch one cycle short of the debounce window
    press(5'b00100, DEB - 1, 30);
    check("glitch_none", sent_q.size(), 1);

    // D and C together: only D, no overflow
    press(5'b01001, 10, 30);
    check("dc_count", sent_q.size(), 2);
    check("dc_byte", sent_at(1), 8'h44);
    check("dc_ovf", overflow, 1'b0);

    // Busy never rises: second byte follows after the timeout
    press(5'b00010, 8, 8);
    press(5'b00001, 8, 8);
    wait_sent(4, 60, "tmo_count");
    check("tmo_byte0", sent_at(2), 8'h32);
    check("tmo_byte1", sent_at(3), 8'h58);
    check("tmo_gap", (sent_cyc.size() > 3) ? sent_cyc[3] - sent_cyc[2] : -1, TMO + 2);
    tick(30);

    // Busy held: fill the queue, overflow on the fifth press
    busy_man = 1'b1;
    press(5'b10000, 6, 6);
    press(5'b01000, 6, 6);
    press(5'b00100, 6, 6);
    check("fill3_full", fifo_full, 1'b0);
    press(5'b00010, 6, 6);
    check("fill4_full", fifo_full, 1'b1);
    check("fill4_ovf", overflow, 1'b0);
    press(5'b00001, 6, 6);
    check("fill5_ovf", overflow, 1'b1);
    check("fill5_sent", sent_q.size(), 4);
    base = sent_q.size();
    auto_mode = 1'b1;
    busy_man = 1'b0;
    wait_sent(base + 4, 200, "drain_count");
    check("drain0", sent_at(base + 0), 8'h55);
    check("drain1", sent_at(base + 1), 8'h44);
    check("drain2", sent_at(base + 2), 8'h4C);
    check("drain3", sent_at(base + 3), 8'h32);
    tick(40);
    check("drain_no_extra", sent_q.size(), base + 4);
    check("drain_ovf_sticky", overflow, 1'b1);
    check("drain_full", fifo_full, 1'b0);
    auto_mode = 1'b0;
    tick(10);

    // Reset while waiting for busy to drop, two bytes queued
    base = sent_q.size();
    btn_v = 5'b10000;
    wait_sent(base + 1, 40, "wd_first");
    busy_man = 1'b1;
    tick(3);
    btn_v = 5'b0;
    tick(8);
    press(5'b01000, 6, 6);
    press(5'b00100, 6, 6);
    check("wd_data_before", uart_tx_data, 8'h55);
    reset = 1'b1;
    #1;
    check("wd_rst_en", uart_tx_en, 1'b0);
    check("wd_rst_data", uart_tx_data, 8'h00);
    check("wd_rst_full", fifo_full, 1'b0);
    check("wd_rst_ovf", overflow, 1'b0);
    tick(3);
    reset = 1'b0;
    busy_man = 1'b0;
    tick(60);
    check("wd_no_send", sent_q.size(), base + 1);

    // Button held through reset must be released before it counts
    base = sent_q.size();
    btn_v = 5'b00010;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(30);
    check("held_no_press", sent_q.size(), base);
    btn_v = 5'b0;
    tick(10);
    press(5'b00010, 8, 4);
    wait_sent(base + 1, 40, "held_repress");
    check("held_byte", sent_at(base), 8'h32);
    tick(30);

    // Randomized presses and glitches against the queue model
    auto_mode = 1'b1;
    base = sent_q.size();
    exp_q.delete();
    for (int e = 0; e < 14; e++) begin
      m = 5'($urandom_range(31, 1));
      if ($urandom_range(3, 0) == 0) begin
        hold = $urandom_range(DEB - 1, 1);
      end else begin
        hold = $urandom_range(DEB + 6, DEB);
        exp_q.push_back(code_of(m));
      end
      press(m, hold, $urandom_range(DEB + 8, DEB + 2));
    end
    wait_sent(base + exp_q.size(), 400, "rand_count");
    for (int i = 0; i < exp_q.size(); i++) check("rand_byte", sent_at(base + i), exp_q[i]);
    tick(40);
    check("rand_no_extra", sent_q.size(), base + exp_q.size());
    check("rand_ovf", overflow, 1'b0);
    check("no_double_en", double_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
